// File: rtl/cla_nibble_seq.sv
// Sequences an external 4-bit CLA slice over NIB nibbles, LSB first, to build a W-bit add/sub.
// Result and N/Z/V/C flags are returned on a valid/ready response channel.
module cla_nibble_seq #(
  parameter int unsigned NIB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_sub,
  input  logic               req_cin,
  input  logic [4*NIB-1:0]   req_a,
  input  logic [4*NIB-1:0]   req_b,
  output logic [3:0]         cla_a,
  output logic [3:0]         cla_b,
  output logic               cla_cin,
  input  logic [3:0]         cla_s,
  input  logic               cla_g,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [4*NIB-1:0]   rsp_sum,
  output logic               rsp_n,
  output logic               rsp_z,
  output logic               rsp_v,
  output logic               rsp_c,
  output logic               busy
);

  localparam int unsigned W    = 4 * NIB;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    c_d     = c_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d     = req_a;
          // Subtraction is A + ~B + 1: invert B once here, force carry-in high.
          b_d     = req_sub ? ~req_b : req_b;
          carry_d = req_sub | req_cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[{cnt_q, 2'b00} +: 4] = cla_s;
        carry_d                     = cla_g;
        if (cnt_q == CntW'(NIB - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
          sum_d   = work_d;
          n_d     = work_d[W-1];
          z_d     = (work_d == '0);
          v_d     = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
          c_d     = cla_g;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;
    if (state_q == StRun) begin
      cla_a   = a_q[{cnt_q, 2'b00} +: 4];
      cla_b   = b_q[{cnt_q, 2'b00} +: 4];
      cla_cin = carry_q;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign rsp_sum   = sum_q;
  assign rsp_n     = n_q;
  assign rsp_z     = z_q;
  assign rsp_v     = v_q;
  assign rsp_c     = c_q;

endmodule

// File: doc/cla_nibble_seq.md
Name: cla_nibble_seq

Overview:
- Multi-cycle controller that sequences one shared 4-bit carry-lookahead adder slice (ports A, B, Cin in; S, P, G out) to perform NIB×4-bit add/subtract in the Execute stage.
- Accepts one operation per valid/ready handshake and feeds one nibble per cycle, LSB first, chaining carry through a register.
- Returns result plus N/Z/V/C flags on a valid/ready response channel.
- The CLA slice is instantiated outside this block; this block only drives and samples it.

Parameters:
- NIB, 4, number of 4-bit nibbles; datapath width W = 4*NIB (legal 2..8).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  operation request valid
- req_ready  out  1  block can accept a request
- req_sub  in  1  0 = A+B+req_cin, 1 = A-B (A + ~B + 1)
- req_cin  in  1  carry-in for add; ignored when req_sub=1
- req_a  in  W  operand A
- req_b  in  W  operand B
- cla_a  out  4  nibble of A to CLA slice
- cla_b  out  4  nibble of B (inverted if sub) to CLA slice
- cla_cin  out  1  carry-in to CLA slice
- cla_s  in  4  CLA slice sum
- cla_g  in  1  CLA slice group generate (includes P&Cin term) = nibble carry-out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  W  result
- rsp_n  out  1  rsp_sum[W-1]
- rsp_z  out  1  rsp_sum == 0
- rsp_v  out  1  signed overflow
- rsp_c  out  1  final carry-out (for sub: 1 = no borrow)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, nibble counter=0, carry reg=0, all result/flag regs=0, rsp_valid=0, req_ready=1, busy=0; cla_a/cla_b/cla_cin=0.
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid&req_ready at edge T: latch A, B_eff = req_sub ? ~req_b : req_b, carry = req_sub ? 1 : req_cin; cnt=0; go RUN.
- RUN (cycles T+1..T+NIB): cla_a=A[4cnt+3:4cnt], cla_b=B_eff nibble cnt, cla_cin=carry (combinational from regs). Each edge: sum nibble cnt <= cla_s; carry <= cla_g; cnt++. On edge with cnt==NIB-1: compute flags, go DONE.
- Flags at the final edge: C = cla_g; V = (A[W-1] == B_eff[W-1]) && (sum[W-1] != A[W-1]), using the final cla_s MSB; N, Z from the complete sum.
- DONE: rsp_valid=1 from cycle T+NIB+1; rsp_* held stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready: go IDLE, rsp_valid=0.
- Latency: request accept to rsp_valid = NIB+1 cycles (5 at NIB=4).
- Throughput: one op per NIB+2 cycles minimum. req_ready=0 in RUN and DONE; no request is accepted in the same cycle as a response handshake.
- Outside RUN: cla_a=0, cla_b=0, cla_cin=0.
- rsp_sum/flags: registered, retain the last value in IDLE until the next DONE.
- req_* changes while req_ready=0: ignored.
- Counter: wraps only via state exit; never exceeds NIB-1.
- Reset mid-RUN or mid-DONE: immediate abort to IDLE. Partial result is discarded, rsp_valid drops asynchronously, and no response is produced.

Test Plan:
- Add, req_cin=0, A=0x1234, B=0x1111 -> rsp_sum=0x2345, N=0 Z=0 V=0 C=0; rsp_valid exactly 5 cycles after accept; cla_cin sequence 0,0,0,0.
- Add, A=0xFFFF, B=0x0001 -> sum=0x0000, Z=1 C=1 V=0 N=0; cla_cin sequence 0,1,1,1.
- Add, A=0x7FFF, B=0x0001 -> sum=0x8000, N=1 V=1 C=0 Z=0.
- Sub, A=0x0005, B=0x0005 -> sum=0x0000, Z=1 C=1 V=0; Sub, A=0x8000, B=0x0001 -> sum=0x7FFF, V=1 C=1 N=0.
- Back-pressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_sum/flags stable, req_ready=0, a req_valid pulse is ignored. Then rsp_ready=1 -> IDLE next cycle, req_ready=1.
- Reset asserted on the 2nd RUN cycle of 0x00FF+0x0001 -> outputs immediately at reset values. After release, 0x0001+0x0001 yields 0x0002 with C=0 (no stale carry).
